mul8_seq_ctrl: RTL
==================

Name: mul8_seq_ctrl

Overview:
- Sequencing controller that computes an unsigned 8x8 -> 16-bit product using one shared 4x4 array multiplier core, `multiplier_4bit`.
- The core is time-multiplexed over four nibble-pair partial products, with shift-accumulate into a 16-bit register.
- Sits between an upstream operand source and a downstream result consumer, with valid/ready handshakes on both sides.
- Gives the datapath 8-bit multiply capability without a second, larger array.

Parameters:
- ZERO_BYPASS, 1, when 1 a zero operand skips the MUL steps and yields result 0 one cycle after accept.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- in_a  input  8  multiplicand, unsigned
- in_b  input  8  multiplier, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_prod  output  16  product in_a*in_b
- busy  output  1  state != IDLE
- ops_done  output  CNT_W  count of results handed off; wraps modulo 2^CNT_W

Behaviour:
- Reset (synchronous, wins over every other event, including mid-operation):
  - state=IDLE, step=0, acc=0, operand regs=0, ops_done=0.
  - Outputs: out_valid=0, out_prod=0, busy=0, in_ready=1 (from the first cycle after reset).
  - Any in-flight operation is discarded and produces no output.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at the clock edge: latch a=in_a, b=in_b, clear acc, step=0.
  - If ZERO_BYPASS and (in_a==0 or in_b==0): go to DONE with acc=0.
  - Otherwise go to MUL.
- MUL:
  - in_ready=0. The core inputs are driven combinationally from the latched nibbles selected by step.
  - step0: a[3:0]*b[3:0], shift 0.
  - step1: a[3:0]*b[7:4], shift 4.
  - step2: a[7:4]*b[3:0], shift 4.
  - step3: a[7:4]*b[7:4], shift 8.
  - Each edge: acc <= acc + ({8'b0,pp} << shift), 16-bit add.
  - The partial products cannot overflow 16 bits; no carry-out beyond bit 15 exists for unsigned 8x8.
  - step increments each edge; after the step3 edge go to DONE.
- DONE:
  - out_valid=1; out_prod=acc, held stable while out_valid && !out_ready. in_ready=0.
  - On out_ready at the edge: ops_done += 1 (wraps), go to IDLE.
- Latency, with no backpressure:
  - Normal path: out_valid is high in the 5th cycle after the accept edge (4 MUL cycles, then DONE).
  - Bypass path: out_valid is high in the cycle immediately after the accept edge.
- Throughput: at most one result per 6 cycles (normal path). No overlap of a new accept with DONE.
- out_prod outside DONE: drives acc. Consumers must qualify it with out_valid.
- in_a/in_b changes while not accepted are ignored; operands are sampled only at the accept edge.
- out_ready asserted while not in DONE has no effect.

Decomposition:
- Shared package mul_ctrl_pkg:
  - state enum {IDLE, MUL, DONE}.
  - STEP_W=2.
  - Shift-amount constants SHIFT_LL=0, SHIFT_LH=4, SHIFT_HL=4, SHIFT_HH=8.
- Sub-module: one instance of the existing 4x4 array multiplier `multiplier_4bit`, ports product, inp1, inp2, unmodified.
- The nibble mux, accumulator and FSM stay in mul8_seq_ctrl.

Test Plan:
- Basic product: accept a=0x12, b=0x34 with out_ready=1 -> out_valid exactly 5 cycles after accept, out_prod=0x03A8, ops_done=1.
- Maximum operands: a=0xFF, b=0xFF -> out_prod=0xFE01; a=0x0F, b=0xF0 -> 0x0E10; a=0x80, b=0x02 -> 0x0100.
- Zero bypass: a=0x00, b=0xAB with ZERO_BYPASS=1 -> out_prod=0x0000, 1-cycle latency. Same input with ZERO_BYPASS=0 -> 0x0000 at 5-cycle latency.
- Backpressure: a=0x07, b=0x09, out_ready=0 for 10 cycles -> out_valid and out_prod=0x003F stable, in_ready=0 throughout, ops_done unchanged. Raise out_ready -> one handoff, IDLE next cycle.
- Reset mid-operation: assert rst during MUL step2 of a=0xAA, b=0x55 -> next cycle IDLE, in_ready=1, out_valid=0, ops_done=0. Then 0x03*0x05 -> 0x000F.
- Counter wrap: with CNT_W=4, complete 17 operations -> ops_done=1. in_valid held continuously -> one accept per 6 cycles, no operand lost or duplicated.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the sequential 8x8 multiply controller:
// FSM states, step counter width and per-step shift amounts.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int STEP_W   = 2;
  localparam int SHIFT_LL = 0;
  localparam int SHIFT_LH = 4;
  localparam int SHIFT_HL = 4;
  localparam int SHIFT_HH = 8;

endpackage

// File: rtl/multiplier_4bit.sv
// Combinational 4x4 unsigned array multiplier.
// Each row is one gated copy of inp1, weighted by the position of the inp2 bit.
module multiplier_4bit (
  output logic [7:0] product,
  input  logic [3:0] inp1,
  input  logic [3:0] inp2
);

  // Sum the four partial-product rows.
  always_comb begin
    product = 8'd0;
    for (int i = 0; i < 4; i++) begin
      product = product + ({4'd0, inp1 & {4{inp2[i]}}} << i);
    end
  end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 -> 16 unsigned multiplier built on one shared 4x4 core:
// four nibble-pair steps accumulated into a 16-bit register, valid/ready on both sides.
module mul8_seq_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_prod,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_e            state_q;
  logic [STEP_W-1:0] step_q;
  logic [7:0]        a_q;
  logic [7:0]        b_q;
  logic [15:0]       acc_q;
  logic [15:0]       acc_d;
  logic [CNT_W-1:0]  ops_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;

  logic [3:0]        nib_a_s;
  logic [3:0]        nib_b_s;
  logic [3:0]        shift_s;
  logic [7:0]        pp_s;
  logic              zero_s;

  multiplier_4bit u_core (
    .product (pp_s),
    .inp1    (nib_a_s),
    .inp2    (nib_b_s)
  );

  // Step selects the nibble pair and its weight; accumulate the weighted partial product.
  always_comb begin
    nib_a_s = a_q[3:0];
    nib_b_s = b_q[3:0];
    shift_s = 4'(SHIFT_LL);
    case (step_q)
      2'd0: begin
        nib_a_s = a_q[3:0];
        nib_b_s = b_q[3:0];
        shift_s = 4'(SHIFT_LL);
      end
      2'd1: begin
        nib_a_s = a_q[3:0];
        nib_b_s = b_q[7:4];
        shift_s = 4'(SHIFT_LH);
      end
      2'd2: begin
        nib_a_s = a_q[7:4];
        nib_b_s = b_q[3:0];
        shift_s = 4'(SHIFT_HL);
      end
      2'd3: begin
        nib_a_s = a_q[7:4];
        nib_b_s = b_q[7:4];
        shift_s = 4'(SHIFT_HH);
      end
      default: begin
        nib_a_s = 4'd0;
        nib_b_s = 4'd0;
        shift_s = 4'd0;
      end
    endcase
    acc_d  = acc_q + ({8'd0, pp_s} << shift_s);
    zero_s = (in_a == 8'd0) || (in_b == 8'd0);
  end

  // Controller FSM; handshake and status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= {STEP_W{1'b0}};
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      acc_q       <= 16'd0;
      ops_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            acc_q      <= 16'd0;
            step_q     <= {STEP_W{1'b0}};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (ZERO_BYPASS && zero_s) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          acc_q  <= acc_d;
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            ops_q       <= ops_q + CNT_W'(1);
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prod  = acc_q;
  assign busy      = busy_q;
  assign ops_done  = ops_q;

endmodule
